// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, register address width,
// multiply/divide op encodings and the muldiv FSM state encoding.
package cpu_pkg;

    localparam int XLEN   = 32;
    localparam int REG_AW = 5;

    typedef enum logic [1:0] {
        OP_MUL   = 2'd0,
        OP_MULHU = 2'd1,
        OP_DIVU  = 2'd2,
        OP_REMU  = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    function automatic logic op_is_div(input op_t o);
        return (o == OP_DIVU) || (o == OP_REMU);
    endfunction

endpackage

// File: rtl/muldiv_unit_if.sv
// Issue-side request and register-file write-back signals of the muldiv unit.
interface muldiv_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
);

    logic              start;
    op_t               op;
    logic [XLEN-1:0]   rda;
    logic [XLEN-1:0]   rdb;
    logic [REG_AW-1:0] rd;
    logic              busy;
    logic [REG_AW-1:0] wa;
    logic [XLEN-1:0]   wda;
    logic              reg_wr;

    modport master (
        output start, op, rda, rdb, rd,
        input  busy, wa, wda, reg_wr
    );

    modport slave (
        input  start, op, rda, rdb, rd,
        output busy, wa, wda, reg_wr
    );

endinterface

// File: rtl/muldiv_unit.sv
// Multi-cycle unsigned multiply/divide: XLEN shift-add or restoring
// shift-subtract iterations, then a single-cycle register-file write-back.
module muldiv_unit
    import cpu_pkg::*;
#(
    parameter int XLEN = cpu_pkg::XLEN
) (
    input  logic          clk,
    input  logic          reset,
    muldiv_unit_if.slave  bus
);

    localparam int CW = $clog2(XLEN);

    state_t            state, state_next;
    op_t               op_q;
    logic [REG_AW-1:0] rd_q;
    logic [XLEN:0]     hi;
    logic [XLEN-1:0]   lo;
    logic [XLEN-1:0]   b_q;
    logic [CW-1:0]     cnt;
    logic [REG_AW-1:0] wa_q;
    logic [XLEN-1:0]   wda_q;
    logic              busy;
    logic              reg_wr;
    logic              last_iter;
    logic [2*XLEN:0]   step_out;
    logic [XLEN-1:0]   result;

    // MUL: hi:lo is the product, low half starts as the multiplier and drains out.
    // DIV: hi is the partial remainder, lo shifts dividend bits out and quotient bits in.
    function automatic logic [2*XLEN:0] step(
        input logic            is_div,
        input logic [XLEN:0]   h,
        input logic [XLEN-1:0] l,
        input logic [XLEN-1:0] b
    );
        logic [XLEN:0] sum;
        logic [XLEN:0] shifted;
        if (!is_div) begin
            sum = {1'b0, h[XLEN-1:0]} + (l[0] ? {1'b0, b} : '0);
            return {1'b0, sum, l[XLEN-1:1]};
        end else begin
            shifted = {h[XLEN-1:0], l[XLEN-1]};
            if (shifted >= {1'b0, b})
                return {shifted - {1'b0, b}, l[XLEN-2:0], 1'b1};
            else
                return {shifted, l[XLEN-2:0], 1'b0};
        end
    endfunction

    assign last_iter = (cnt == CW'(XLEN - 1));
    assign step_out  = step(op_is_div(op_q), hi, lo, b_q);
    assign result    = ((op_q == OP_MUL) || (op_q == OP_DIVU)) ? step_out[XLEN-1:0]
                                                               : step_out[2*XLEN-1:XLEN];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            state <= ST_IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        reg_wr     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.start)
                    state_next = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (last_iter)
                    state_next = ST_WB;
            end
            ST_WB: begin
                busy       = 1'b1;
                reg_wr     = (rd_q != '0);
                state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_q  <= OP_MUL;
            rd_q  <= '0;
            hi    <= '0;
            lo    <= '0;
            b_q   <= '0;
            cnt   <= '0;
            wa_q  <= '0;
            wda_q <= '0;
        end else if (state == ST_IDLE) begin
            if (bus.start) begin
                op_q <= bus.op;
                rd_q <= bus.rd;
                hi   <= '0;
                lo   <= op_is_div(bus.op) ? bus.rda : bus.rdb;
                b_q  <= op_is_div(bus.op) ? bus.rdb : bus.rda;
                cnt  <= '0;
            end
        end else if (state == ST_RUN) begin
            hi  <= step_out[2*XLEN:XLEN];
            lo  <= step_out[XLEN-1:0];
            cnt <= cnt + 1'b1;
            // The write-back registers load from the final iteration's result directly.
            if (last_iter) begin
                wa_q  <= rd_q;
                wda_q <= result;
            end
        end
    end

    assign bus.busy   = busy;
    assign bus.reg_wr = reg_wr;
    assign bus.wa     = wa_q;
    assign bus.wda    = wda_q;

endmodule
